// File: rtl/seq_function_unit.sv
// Multi-cycle function unit: single-cycle ALU ops plus iterative shifts and a
// shift-add unsigned multiplier, with registered result/flags and START/BUSY/DONE.
module seq_function_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [3:0]       FS,
    input  logic [WIDTH-1:0] BUS_A,
    input  logic [WIDTH-1:0] BUS_B,
    output logic [WIDTH-1:0] F,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   opa, mplier;
    logic [2*WIDTH-1:0] acc, acc_nxt;
    logic [CW-1:0]      count;
    logic               shl;

    logic               is_shift, is_mul;
    logic [4:0]         shamt;
    logic               last_step;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res_f;
    logic               res_v, res_c;

    logic [WIDTH-1:0]   sh_nxt;
    logic               sh_out;
    logic [WIDTH:0]     madd;

    assign is_shift  = (FS == 4'd8) || (FS == 4'd9);
    assign is_mul    = (FS == 4'd10);
    assign shamt     = BUS_B[4:0];
    assign last_step = (count == CW'(1));

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    if (is_mul)                          state_nxt = S_MUL;
                    else if (is_shift && shamt != 5'd0)  state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: if (last_step) state_nxt = S_IDLE;
            S_MUL:   if (last_step) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = (state != S_IDLE);
    end

    // Single-cycle result, also covers shifts by zero (F=A, C=0)
    always_comb begin
        sum   = '0;
        res_f = '0;
        res_v = 1'b0;
        res_c = 1'b0;
        case (FS)
            4'd0: res_f = BUS_A;
            4'd1: begin
                sum   = {1'b0, BUS_A} + {1'b0, BUS_B};
                res_f = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (BUS_A[WIDTH-1] == BUS_B[WIDTH-1]) && (sum[WIDTH-1] != BUS_A[WIDTH-1]);
            end
            4'd2: begin
                sum   = {1'b0, BUS_A} + {1'b0, ~BUS_B} + {{WIDTH{1'b0}}, 1'b1};
                res_f = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (BUS_A[WIDTH-1] != BUS_B[WIDTH-1]) && (sum[WIDTH-1] != BUS_A[WIDTH-1]);
            end
            4'd3:       res_f = BUS_A & BUS_B;
            4'd4:       res_f = BUS_A | BUS_B;
            4'd5:       res_f = BUS_A ^ BUS_B;
            4'd6:       res_f = ~BUS_A;
            4'd7:       res_f = BUS_B;
            4'd8, 4'd9: res_f = BUS_A;
            default:    res_f = '0;
        endcase
    end

    // One iteration of the shifter and of the shift-add multiplier
    always_comb begin
        sh_nxt  = shl ? (opa << 1) : (opa >> 1);
        sh_out  = shl ? opa[WIDTH-1] : opa[0];
        madd    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
        acc_nxt = {madd, acc[WIDTH-1:1]};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            F      <= '0;
            V      <= 1'b0;
            C      <= 1'b0;
            N      <= 1'b0;
            Z      <= 1'b0;
            DONE   <= 1'b0;
            opa    <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            shl    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        if (is_mul) begin
                            opa    <= BUS_A;
                            mplier <= BUS_B;
                            acc    <= '0;
                            count  <= CW'(WIDTH);
                        end else if (is_shift && shamt != 5'd0) begin
                            opa   <= BUS_A;
                            shl   <= (FS == 4'd8);
                            count <= CW'(shamt);
                        end else begin
                            F    <= res_f;
                            V    <= res_v;
                            C    <= res_c;
                            N    <= res_f[WIDTH-1];
                            Z    <= (res_f == '0);
                            DONE <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    opa   <= sh_nxt;
                    count <= count - CW'(1);
                    if (last_step) begin
                        F    <= sh_nxt;
                        V    <= 1'b0;
                        C    <= sh_out;
                        N    <= sh_nxt[WIDTH-1];
                        Z    <= (sh_nxt == '0);
                        DONE <= 1'b1;
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    if (last_step) begin
                        F    <= acc_nxt[WIDTH-1:0];
                        V    <= 1'b0;
                        C    <= (acc_nxt[2*WIDTH-1:WIDTH] != '0);
                        N    <= acc_nxt[WIDTH-1];
                        Z    <= (acc_nxt[WIDTH-1:0] == '0);
                        DONE <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_function_unit.sv
// Directed bench for seq_function_unit: hand-computed results, flags and
// handshake timing for ALU, shift, multiply, busy-ignore and reset-abort cases.
module tb_seq_function_unit;
    logic        CLK = 1'b0;
    logic        RESET, START;
    logic [3:0]  FS;
    logic [31:0] BUS_A, BUS_B, F;
    logic        V, C, N, Z, BUSY, DONE;

    int tests = 0;
    int fails = 0;
    int cyc;
    int ndone;

    seq_function_unit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FS(FS),
        .BUS_A(BUS_A), .BUS_B(BUS_B), .F(F),
        .V(V), .C(C), .N(N), .Z(Z), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b);
        START = 1'b1; FS = fs; BUS_A = a; BUS_B = b;
        tick();
        START = 1'b0;
    endtask

    // Counts cycles from the one after the START edge (=1) until DONE, bounded
    task automatic wait_done(output int n);
        n = 1;
        while (!DONE && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; FS = '0; BUS_A = '0; BUS_B = '0;
        tick(); tick();
        RESET = 1'b0;
        chk("reset_f", F, 32'h0);
        chk("reset_flags", {28'b0, V, C, N, Z}, 32'h0);
        chk("reset_busy_done", {30'b0, BUSY, DONE}, 32'h0);

        // ADD overflow
        issue(4'd1, 32'h7FFF_FFFF, 32'h1);
        chk("add_done", {31'b0, DONE}, 32'h1);
        chk("add_f", F, 32'h8000_0000);
        chk("add_vcnz", {28'b0, V, C, N, Z}, 32'hA);
        tick();
        chk("add_done_pulse", {31'b0, DONE}, 32'h0);
        chk("add_f_held", F, 32'h8000_0000);

        // SUB equal, then back-to-back SUB with borrow
        issue(4'd2, 32'd5, 32'd5);
        chk("sub_eq_done", {31'b0, DONE}, 32'h1);
        chk("sub_eq_f", F, 32'h0);
        chk("sub_eq_vcnz", {28'b0, V, C, N, Z}, 32'h5);
        issue(4'd2, 32'd0, 32'd1);
        chk("sub_borrow_done", {31'b0, DONE}, 32'h1);
        chk("sub_borrow_f", F, 32'hFFFF_FFFF);
        chk("sub_borrow_vcnz", {28'b0, V, C, N, Z}, 32'h2);

        issue(4'd5, 32'hF0F0_1234, 32'h0F0F_1234);
        chk("xor_f", F, 32'hFFFF_0000);
        issue(4'd12, 32'h1234, 32'h5678);
        chk("undef_f", F, 32'h0);
        chk("undef_vcnz", {28'b0, V, C, N, Z}, 32'h1);

        // LSL by 4
        issue(4'd8, 32'h8000_0001, 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("lsl_busy_%0d", i), {30'b0, BUSY, DONE}, 32'h2);
            tick();
        end
        chk("lsl_done", {30'b0, BUSY, DONE}, 32'h1);
        chk("lsl_f", F, 32'h0000_0010);
        chk("lsl_vcnz", {28'b0, V, C, N, Z}, 32'h0);
        // LSR by 0 issued in the DONE cycle
        issue(4'd9, 32'h0000_000F, 32'd0);
        chk("lsr0_done", {31'b0, DONE}, 32'h1);
        chk("lsr0_f", F, 32'hF);
        chk("lsr0_vcnz", {28'b0, V, C, N, Z}, 32'h0);
        // LSR by 1 shifting out a one
        issue(4'd9, 32'h3, 32'd1);
        wait_done(cyc);
        chk("lsr1_lat", cyc, 32'd2);
        chk("lsr1_f", F, 32'h1);
        chk("lsr1_vcnz", {28'b0, V, C, N, Z}, 32'h4);

        // MUL with high-half product, then back-to-back MUL
        issue(4'd10, 32'h0001_0000, 32'h0001_0000);
        wait_done(cyc);
        chk("mul1_lat", cyc, 32'd33);
        chk("mul1_busy_in_done", {31'b0, BUSY}, 32'h0);
        chk("mul1_f", F, 32'h0);
        chk("mul1_vcnz", {28'b0, V, C, N, Z}, 32'h5);
        issue(4'd10, 32'd3, 32'd7);
        wait_done(cyc);
        chk("mul2_lat", cyc, 32'd33);
        chk("mul2_f", F, 32'd21);
        chk("mul2_vcnz", {28'b0, V, C, N, Z}, 32'h0);
        tick();

        // START while busy and operand changes are ignored
        issue(4'd10, 32'd3, 32'd7);
        BUS_A = 32'hDEAD_BEEF; BUS_B = 32'h1;
        tick(); tick(); tick();
        START = 1'b1; FS = 4'd1; BUS_A = 32'h1111; BUS_B = 32'h2222;
        tick();
        START = 1'b0; BUS_A = 32'hFFFF_FFFF; BUS_B = 32'hFFFF_FFFF; FS = 4'd10;
        cyc = 5;
        while (!DONE && cyc < 40) begin
            chk($sformatf("ign_f_held_%0d", cyc), F, 32'd21);
            tick();
            cyc++;
        end
        chk("ign_lat", cyc, 32'd33);
        chk("ign_f", F, 32'd21);
        tick();
        chk("ign_single_done", {31'b0, DONE}, 32'h0);

        // Reset mid-shift, with a START at the same edge
        issue(4'd9, 32'hFFFF_FFFF, 32'd20);
        tick(); tick();
        RESET = 1'b1; START = 1'b1; FS = 4'd7; BUS_B = 32'h55;
        tick();
        RESET = 1'b0; START = 1'b0;
        chk("rst_abort_f", F, 32'h0);
        chk("rst_abort_flags", {28'b0, V, C, N, Z}, 32'h0);
        chk("rst_abort_busy_done", {30'b0, BUSY, DONE}, 32'h0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (DONE || BUSY) ndone++;
            tick();
        end
        chk("rst_no_done", ndone, 32'd0);
        chk("rst_f_still_zero", F, 32'h0);
        issue(4'd7, 32'h0, 32'h1234);
        chk("post_rst_done", {31'b0, DONE}, 32'h1);
        chk("post_rst_f", F, 32'h1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
